mem_wb_pipe_reg: RTL and testbench
==================================

// Module: mem_wb_pipe_reg
// PURPOSE
//  Parametrised MEM/WB pipeline register with an elastic valid/ready handshake, flush and a
//  2-entry skid buffer. Sits between the memory stage and write-back. Holds the beat under stall
//  with a registered in_ready, so no combinational path runs from WB ready back into MEM.
//  Inserts bubbles on flush. Gates write controls of invalid beats so a bubble never writes.
// PARAMETERS
//  DATA_W      32  width of alu_result / read_data
//  REG_ADDR_W  5   width of rd_num
//  SKID_EN     1   1: 2-entry skid, in_ready registered; 0: single entry, in_ready = out_ready | ~out_valid
//  X0_SQUASH   1   1: reg_write_out forced 0 when rd_num_out == 0
// PORTS
//  clk               in   1           clock, rising edge
//  rst_n             in   1           async active-low reset
//  flush             in   1           sync: discard all held beats and the current input beat
//  in_valid          in   1           MEM beat valid
//  in_ready          out  1           register can accept a beat this cycle
//  mem_write_en      in   1           MEM-stage store enable
//  mem_to_reg        in   1           WB mux select: 1 = read_data, 0 = alu_result
//  reg_write         in   1           register-file write enable
//  alu_result        in   DATA_W      ALU result
//  read_data         in   DATA_W      load data
//  rd_num            in   REG_ADDR_W  destination register
//  out_valid         out  1           WB beat valid
//  out_ready         in   1           WB consumes the beat this cycle
//  mem_write_en_out  out  1           held store enable, gated by out_valid
//  mem_to_reg_out    out  1           held
//  reg_write_out     out  1           held, gated by out_valid and X0_SQUASH
//  alu_result_out    out  DATA_W      held
//  read_data_out     out  DATA_W      held
//  rd_num_out        out  REG_ADDR_W  held
// BEHAVIOUR
//  - Reset (async assert, sync release): all state EMPTY. All *_out = 0, out_valid = 0.
//    in_ready = 1 in the first cycle after release.
//  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready. Evaluate at posedge.
//  - Latency 1 cycle when empty: a beat accepted at edge N is presented after edge N.
//  - FSM (SKID_EN=1), based on the main and skid entries:
//      EMPTY: in xfer -> FULL (load main).
//      FULL:  in & out -> FULL (main <= input); in only -> SKID (load skid);
//             out only -> EMPTY; neither -> hold.
//      SKID:  in_ready = 0. Out xfer -> FULL (main <= skid). Otherwise hold.
//  - in_ready = (state != SKID), registered. Order always preserved; no beat lost or duplicated.
//  - SKID_EN=0: EMPTY/FULL only. in_ready = out_ready | ~out_valid, combinational.
//  - flush has priority over every other event: next state EMPTY, input beat dropped, out_valid = 0
//    next cycle. A beat presented with out_valid & out_ready in the flush cycle is still consumed.
//  - Gating: mem_write_en_out = main.mem_write_en & out_valid.
//    reg_write_out = main.reg_write & out_valid & ~(X0_SQUASH & rd_num_out == 0).
//  - Data fields of an invalid entry keep their last value; only the control bits are gated.
//  - Simultaneous in/out xfer in FULL gives full throughput: 1 beat/cycle, no bubbles.
//  - Reset mid-operation: immediate EMPTY, and held beats are discarded.
// STRUCTURE
//  - pipe_pkg: typedef struct packed mem_wb_t {mem_write_en, mem_to_reg, reg_write,
//    alu_result, read_data, rd_num}, parametrised by DATA_W/REG_ADDR_W. Also state enum
//    pipe_state_e {EMPTY, FULL, SKID}.
//  - Sub-module pipe_skid_buf #(type T): generic 2-entry skid with flush. This block instantiates
//    it with mem_wb_t and adds the output gating.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, all outputs 0 at once; in_ready=1 after release.
//  2 Streaming: out_ready=1, 8 beats rd_num=1..8 back-to-back -> 8 outputs in order, 1/cycle, latency 1.
//  3 Stall: out_ready=0 while 3 beats offered -> 2 accepted (FULL then SKID), in_ready=0;
//    out_ready=1 -> beats 1,2,3 emerge in order, none lost.
//  4 Flush in SKID state with in_valid=1 -> next cycle out_valid=0, in_ready=1, all 3 beats discarded.
//  5 Gating: beat reg_write=1, rd_num=0 -> reg_write_out=0. Same beat with rd_num=5 -> reg_write_out=1.
//    Bubble -> mem_write_en_out=0.
//  6 Mode: SKID_EN=0, out_ready toggling 1010 -> in_ready tracks out_ready combinationally; order kept.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the MEM/WB pipeline register: beat layout at the default
// core widths and the holding-state encoding of the elastic buffer.
package pipe_pkg;

  localparam int PIPE_DATA_W     = 32;
  localparam int PIPE_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic                       mem_write_en;
    logic                       mem_to_reg;
    logic                       reg_write;
    logic [PIPE_DATA_W-1:0]     alu_result;
    logic [PIPE_DATA_W-1:0]     read_data;
    logic [PIPE_REG_ADDR_W-1:0] rd_num;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// MEM-to-WB handshake bundle. master = MEM/WB environment, slave = pipeline register.
interface mem_wb_pipe_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_write_en;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     read_data;
  logic [REG_ADDR_W-1:0] rd_num;

  logic                  out_valid;
  logic                  out_ready;
  logic                  mem_write_en_out;
  logic                  mem_to_reg_out;
  logic                  reg_write_out;
  logic [DATA_W-1:0]     alu_result_out;
  logic [DATA_W-1:0]     read_data_out;
  logic [REG_ADDR_W-1:0] rd_num_out;

  modport master (
    output flush, in_valid, mem_write_en, mem_to_reg, reg_write,
           alu_result, read_data, rd_num, out_ready,
    input  in_ready, out_valid, mem_write_en_out, mem_to_reg_out,
           reg_write_out, alu_result_out, read_data_out, rd_num_out
  );

  modport slave (
    input  flush, in_valid, mem_write_en, mem_to_reg, reg_write,
           alu_result, read_data, rd_num, out_ready,
    output in_ready, out_valid, mem_write_en_out, mem_to_reg_out,
           reg_write_out, alu_result_out, read_data_out, rd_num_out
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry elastic buffer with flush. With SKID_EN the upstream ready is
// a flop, so no combinational path runs from out_ready back to in_ready.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter type T       = logic,
  parameter bit  SKID_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  pipe_state_e r_state;
  T            r_main;
  T            r_skid;
  logic        r_in_ready;

  logic        w_in_xfer;
  logic        w_out_xfer;

  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;
  assign in_ready   = SKID_EN ? r_in_ready : (out_ready | ~out_valid);
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // NOTE: state flops use <= so every branch sees pre-edge values of r_main/r_skid.
  // NOTE: the data entries are reset too, so every held output reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      // Data entries keep their contents; only occupancy is discarded.
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= in_data;
            r_state <= FULL;
          end
        end
        FULL: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= in_data;
          end else if (w_in_xfer && SKID_EN) begin
            r_skid     <= in_data;
            r_state    <= SKID;
            r_in_ready <= 1'b0;
          end else if (w_out_xfer) begin
            r_state <= EMPTY;
          end
        end
        SKID: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_state    <= FULL;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: elastic hold of one MEM beat (plus optional skid entry)
// with write controls gated so a bubble or an x0 destination never writes.
module mem_wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit SKID_EN    = 1'b1,
  parameter bit X0_SQUASH  = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  mem_wb_pipe_reg_if.slave bus
);

  // Same layout as pipe_pkg::mem_wb_t, but sized by this instance's parameters.
  typedef struct packed {
    logic                  mem_write_en;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     read_data;
    logic [REG_ADDR_W-1:0] rd_num;
  } beat_t;

  beat_t w_in_beat;
  beat_t w_main;
  logic  w_out_valid;
  logic  w_x0_dest;

  assign w_in_beat.mem_write_en = bus.mem_write_en;
  assign w_in_beat.mem_to_reg   = bus.mem_to_reg;
  assign w_in_beat.reg_write    = bus.reg_write;
  assign w_in_beat.alu_result   = bus.alu_result;
  assign w_in_beat.read_data    = bus.read_data;
  assign w_in_beat.rd_num       = bus.rd_num;

  pipe_skid_buf #(
    .T       (beat_t),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (w_in_beat),
    .out_valid (w_out_valid),
    .out_ready (bus.out_ready),
    .out_data  (w_main)
  );

  assign w_x0_dest = X0_SQUASH && (w_main.rd_num == '0);

  assign bus.out_valid        = w_out_valid;
  assign bus.mem_write_en_out = w_main.mem_write_en & w_out_valid;
  assign bus.reg_write_out    = w_main.reg_write & w_out_valid & ~w_x0_dest;
  assign bus.mem_to_reg_out   = w_main.mem_to_reg;
  assign bus.alu_result_out   = w_main.alu_result;
  assign bus.read_data_out    = w_main.read_data;
  assign bus.rd_num_out       = w_main.rd_num;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: skid and non-skid instances share one stimulus stream
// and are compared every cycle against a queue-based occupancy model.
module tb_mem_wb_pipe_reg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic          mw;
    logic          m2r;
    logic          rw;
    logic [DW-1:0] alu;
    logic [DW-1:0] rdd;
    logic [AW-1:0] rn;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  tb_flush = 1'b0;
  logic  tb_vld = 1'b0;
  logic  tb_ordy = 1'b0;
  beat_t tb_beat = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW)) u_if1 ();
  mem_wb_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW)) u_if0 ();

  assign u_if1.flush        = tb_flush;
  assign u_if1.in_valid     = tb_vld;
  assign u_if1.out_ready    = tb_ordy;
  assign u_if1.mem_write_en = tb_beat.mw;
  assign u_if1.mem_to_reg   = tb_beat.m2r;
  assign u_if1.reg_write    = tb_beat.rw;
  assign u_if1.alu_result   = tb_beat.alu;
  assign u_if1.read_data    = tb_beat.rdd;
  assign u_if1.rd_num       = tb_beat.rn;

  assign u_if0.flush        = tb_flush;
  assign u_if0.in_valid     = tb_vld;
  assign u_if0.out_ready    = tb_ordy;
  assign u_if0.mem_write_en = tb_beat.mw;
  assign u_if0.mem_to_reg   = tb_beat.m2r;
  assign u_if0.reg_write    = tb_beat.rw;
  assign u_if0.alu_result   = tb_beat.alu;
  assign u_if0.read_data    = tb_beat.rdd;
  assign u_if0.rd_num       = tb_beat.rn;

  mem_wb_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .SKID_EN(1'b1), .X0_SQUASH(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1)
  );

  mem_wb_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .SKID_EN(1'b0), .X0_SQUASH(1'b1)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of held beats with capacity 2 (skid) or 1 (no skid).
  // The presented beat is the queue head, or the last head shown once the queue empties.
  beat_t q1[$];
  beat_t q0[$];
  beat_t shown1 = '0;
  beat_t shown0 = '0;
  bit    rdy1   = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete();
      q0.delete();
      shown1 = '0;
      shown0 = '0;
      rdy1   = 1'b1;
    end else begin
      automatic bit o1 = (q1.size() > 0) && tb_ordy;
      automatic bit i1 = tb_vld && rdy1;
      automatic bit o0 = (q0.size() > 0) && tb_ordy;
      automatic bit i0 = tb_vld && (tb_ordy || q0.size() == 0);
      if (tb_flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (o1) void'(q1.pop_front());
        if (i1) q1.push_back(tb_beat);
        if (o0) void'(q0.pop_front());
        if (i0) q0.push_back(tb_beat);
      end
      if (q1.size() > 0) shown1 = q1[0];
      if (q0.size() > 0) shown0 = q0[0];
      rdy1 = tb_flush ? 1'b1 : (q1.size() < 2);
    end
  end

  task automatic cmp_dut(input string tag, input bit ev, input beat_t b, input bit erdy,
                         input logic av, input logic ardy, input logic amw, input logic am2r,
                         input logic arw, input logic [DW-1:0] aalu, input logic [DW-1:0] ardd,
                         input logic [AW-1:0] arn);
    check({tag, ".out_valid"},        av,   ev);
    check({tag, ".in_ready"},         ardy, erdy);
    check({tag, ".mem_write_en_out"}, amw,  b.mw & ev);
    check({tag, ".reg_write_out"},    arw,  b.rw & ev & (b.rn != 0));
    check({tag, ".mem_to_reg_out"},   am2r, b.m2r);
    check({tag, ".alu_result_out"},   aalu, b.alu);
    check({tag, ".read_data_out"},    ardd, b.rdd);
    check({tag, ".rd_num_out"},       arn,  b.rn);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      cmp_dut("skid", q1.size() > 0, shown1, rdy1,
              u_if1.out_valid, u_if1.in_ready, u_if1.mem_write_en_out, u_if1.mem_to_reg_out,
              u_if1.reg_write_out, u_if1.alu_result_out, u_if1.read_data_out, u_if1.rd_num_out);
      cmp_dut("noskid", q0.size() > 0, shown0, tb_ordy | (q0.size() == 0),
              u_if0.out_valid, u_if0.in_ready, u_if0.mem_write_en_out, u_if0.mem_to_reg_out,
              u_if0.reg_write_out, u_if0.alu_result_out, u_if0.read_data_out, u_if0.rd_num_out);
    end
  end

  function automatic beat_t mk(input logic [AW-1:0] rn, input bit rw, input bit mw);
    beat_t b;
    b.mw  = mw;
    b.m2r = 1'($urandom_range(0, 1));
    b.rw  = rw;
    b.alu = $urandom;
    b.rdd = $urandom;
    b.rn  = rn;
    return b;
  endfunction

  task automatic drive(input bit v, input beat_t b, input bit ordy, input bit fl);
    @(negedge clk);
    tb_vld   = v;
    tb_beat  = b;
    tb_ordy  = ordy;
    tb_flush = fl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b1, b2, b3, cur;
    bit    ordy;
    int    nxt;

    // 1: reset release, then reset asserted with beats held
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t1_in_ready_after_release", u_if1.in_ready, 1'b1);
    check("t1_out_valid_after_release", u_if1.out_valid, 1'b0);
    drive(1, mk(5'd7, 1, 1), 0, 0);
    drive(1, mk(5'd8, 1, 1), 0, 0);
    drive(0, mk(5'd9, 1, 1), 0, 0);
    #1;
    check("t1_out_valid_before_reset", u_if1.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_reset_out_valid", u_if1.out_valid, 1'b0);
    check("t1_reset_rd_num", u_if1.rd_num_out, 5'd0);
    check("t1_reset_alu", u_if1.alu_result_out, 32'd0);
    check("t1_reset_mem_write", u_if1.mem_write_en_out, 1'b0);
    check("t1_reset_noskid_valid", u_if0.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t1_in_ready_after_rerelease", u_if1.in_ready, 1'b1);

    // 2: streaming 8 beats with out_ready high, latency 1, one per cycle
    for (int k = 1; k <= 9; k++) begin
      drive(k <= 8, mk(5'(k), 1, 0), 1, 0);
      #1;
      if (k == 1) begin
        check("t2_first_cycle_valid", u_if1.out_valid, 1'b0);
      end else begin
        check("t2_stream_valid", u_if1.out_valid, 1'b1);
        check("t2_stream_rd_num", u_if1.rd_num_out, 5'(k - 1));
      end
    end

    // 3: stall with 3 beats offered, then release
    b1 = mk(5'd1, 1, 0);
    b2 = mk(5'd2, 1, 0);
    b3 = mk(5'd3, 1, 0);
    drive(1, b1, 0, 0);
    drive(1, b2, 0, 0);
    drive(1, b3, 0, 0);
    #1;
    check("t3_in_ready_skid", u_if1.in_ready, 1'b0);
    check("t3_head_stalled", u_if1.rd_num_out, 5'd1);
    drive(1, b3, 1, 0);
    #1;
    check("t3_drain_1", u_if1.rd_num_out, 5'd1);
    drive(1, b3, 1, 0);
    #1;
    check("t3_drain_2", u_if1.rd_num_out, 5'd2);
    check("t3_in_ready_back", u_if1.in_ready, 1'b1);
    drive(0, b3, 1, 0);
    #1;
    check("t3_drain_3", u_if1.rd_num_out, 5'd3);
    check("t3_drain_3_alu", u_if1.alu_result_out, b3.alu);

    // 4: flush while in SKID with in_valid high
    drive(1, b1, 0, 0);
    drive(1, b2, 0, 0);
    drive(1, b3, 0, 1);
    #1;
    check("t4_in_skid", u_if1.in_ready, 1'b0);
    drive(0, b3, 0, 0);
    #1;
    check("t4_flush_out_valid", u_if1.out_valid, 1'b0);
    check("t4_flush_in_ready", u_if1.in_ready, 1'b1);
    drive(0, b3, 1, 0);
    #1;
    check("t4_flush_stays_empty", u_if1.out_valid, 1'b0);

    // 5: write gating on x0 destination and on a bubble
    drive(1, mk(5'd0, 1, 1), 0, 0);
    drive(0, b3, 0, 0);
    #1;
    check("t5_x0_valid", u_if1.out_valid, 1'b1);
    check("t5_x0_reg_write", u_if1.reg_write_out, 1'b0);
    check("t5_x0_mem_write", u_if1.mem_write_en_out, 1'b1);
    drive(1, mk(5'd5, 1, 1), 1, 0);
    drive(0, b3, 1, 0);
    #1;
    check("t5_rd5_reg_write", u_if1.reg_write_out, 1'b1);
    drive(0, b3, 1, 0);
    #1;
    check("t5_bubble_valid", u_if1.out_valid, 1'b0);
    check("t5_bubble_mem_write", u_if1.mem_write_en_out, 1'b0);
    check("t5_bubble_reg_write", u_if1.reg_write_out, 1'b0);
    check("t5_bubble_keeps_rd", u_if1.rd_num_out, 5'd5);

    // 6: non-skid mode, out_ready toggling 1010, in_ready follows combinationally
    nxt = 11;
    cur = mk(5'(nxt), 1, 0);
    for (int t = 0; t < 8; t++) begin
      ordy = (t % 2 == 0);
      drive(1, cur, ordy, 0);
      #1;
      if (t > 0) check("t6_in_ready_tracks", u_if0.in_ready, ordy);
      if (u_if0.in_ready) begin
        nxt++;
        cur = mk(5'(nxt), 1, 0);
      end
    end
    repeat (3) drive(0, cur, 1, 0);

    // Random phase, with occasional reset pulses between edges
    for (int c = 0; c < 3000; c++) begin
      automatic logic [AW-1:0] rn = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      automatic bit v  = ($urandom_range(0, 3) != 0);
      automatic bit o  = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
      automatic bit fl = ($urandom_range(0, 29) == 0);
      drive(v, mk(rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))), o, fl);
      if (c % 700 == 699) begin
        #3;
        rst_n = 1'b0;
        #1;
        check("rand_reset_out_valid", u_if1.out_valid, 1'b0);
        rst_n = 1'b1;
      end
    end
    repeat (4) drive(0, '0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
